fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 9'd0: PC value loaded on reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset: asynchronous, active-low.
REQ-004 stall  input  1  downstream IF/ID register not loading this cycle; hold output.
REQ-005 redirect  input  1  taken branch/jump; flush and refetch.
REQ-006 redirectPC  input  9  word address to fetch after redirect.
REQ-007 imemReq  output  1  single-cycle fetch request strobe.
REQ-008 imemAddr  output  9  word address of the request; valid when imemReq=1.
REQ-009 imemValid  input  1  response strobe, variable latency of at least 1 cycle after imemReq.
REQ-010 imemData  input  32  instruction word; valid when imemValid=1.
REQ-011 instrOut  output  32  fetched instruction to IF/ID; 32'h0 (nop) when fetchValid=0.
REQ-012 nextPCOut  output  9  fetched PC+1, mod 512.
REQ-013 fetchValid  output  1  instrOut/nextPCOut hold a live instruction.

Function
REQ-014 The block SHALL keep a 9-bit word-addressed pc, an output slot (instrOut, nextPCOut, fetchValid), a discard flag, and an FSM with states REQ and WAIT.
REQ-015 At most one imem request SHALL be outstanding at any time.
REQ-016 In REQ, the block SHALL assert imemReq with imemAddr=pc only if fetchValid=0 or stall=0, then move to WAIT; otherwise it SHALL stay in REQ with imemReq=0.
REQ-017 In WAIT, imemReq SHALL be 0; on imemValid with discard=0, the block SHALL load instrOut=imemData, nextPCOut=pc+1, fetchValid=1, pc<=pc+1, and return to REQ.
REQ-018 On imemValid in WAIT with discard=1, the block SHALL drop the data, clear discard, leave pc and the slot unchanged, and return to REQ.
REQ-019 The slot SHALL be consumed at any edge with fetchValid=1 and stall=0; fetchValid SHALL then clear unless a fill occurs on the same edge.
REQ-020 While stall=1 and redirect=0, instrOut, nextPCOut and fetchValid SHALL hold.
REQ-021 A redirect SHALL take priority over stall, fill, and consume: pc<=redirectPC, fetchValid<=0, instrOut<=0, nextPCOut<=0.
REQ-022 If a request is outstanding at the redirect edge, the block SHALL set discard=1 and be in WAIT; this covers WAIT without imemValid, and REQ issuing that cycle.
REQ-023 If redirect and imemValid coincide in WAIT, the data SHALL be dropped, discard SHALL stay 0, and the next state SHALL be REQ.
REQ-024 If redirect arrives in REQ with no request issued, the next state SHALL be REQ, fetching redirectPC.
REQ-025 imemValid SHALL be ignored in REQ (no outstanding request).
REQ-026 The pc increment SHALL wrap from 511 to 0; nextPCOut for pc=511 SHALL be 0.
REQ-027 A response SHALL never arrive into an occupied slot, as guaranteed by REQ-016; no skid storage is required.

Reset
REQ-028 While rst_n=0, the block SHALL force pc=RESET_PC, state=REQ, discard=0, fetchValid=0, instrOut=0, nextPCOut=0, and imemReq=0, asynchronously.
REQ-029 Reset deassertion mid-transaction SHALL leave no memory of the prior request; a late imemValid arriving in REQ is ignored per REQ-025.

Verification
REQ-030 Reset release, 1-cycle memory returning 32'h20010005 for addr 0, stall=0 -> imemReq at addr 0 on cycle 1; fetchValid=1, instrOut=32'h20010005, nextPCOut=1 on cycle 3; next request at addr 1.
REQ-031 Slot full with stall=1 for 4 cycles -> outputs constant, imemReq=0 throughout; stall=0 -> slot consumed, request issued that same cycle.
REQ-032 redirect=1 with redirectPC=9'd100 while in WAIT, response arrives 3 cycles later -> response dropped, fetchValid stays 0, next imemReq at addr 100.
REQ-033 redirect coincident with imemValid, redirectPC=9'd7 -> data dropped, imemReq at addr 7 on the next cycle, no extra discard.
REQ-034 pc=511 fetch -> nextPCOut=0, next imemAddr=0.
REQ-035 rst_n pulsed low while in WAIT with fetchValid=1 -> outputs zeroed immediately, then fetching resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response plus IF/ID slot outputs.
// master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [8:0]  redirectPC;
  logic        imemReq;
  logic [8:0]  imemAddr;
  logic        imemValid;
  logic [31:0] imemData;
  logic [31:0] instrOut;
  logic [8:0]  nextPCOut;
  logic        fetchValid;

  modport master (
    input  stall, redirect, redirectPC, imemValid, imemData,
    output imemReq, imemAddr, instrOut, nextPCOut, fetchValid
  );

  modport slave (
    output stall, redirect, redirectPC, imemValid, imemData,
    input  imemReq, imemAddr, instrOut, nextPCOut, fetchValid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding imem request; slot fills on the response edge (>=2 cycles req->slot).
// Backpressure: stall holds a full slot and blocks new requests; redirect flushes and discards in-flight data.
module fetch_stage #(
  parameter logic [8:0] RESET_PC = 9'd0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  state;
  logic [8:0]  pc;
  logic        discard;
  logic [31:0] instrQ;
  logic [8:0]  nextPCQ;
  logic        validQ;

  logic        issue;
  logic        fill;
  logic        consume;
  logic [8:0]  pcInc;

  // A request is only launched when the slot is free or draining this edge,
  // so a response can never land on an occupied slot.
  assign issue   = rst_n && (state == ST_REQ) && (!validQ || !bus.stall);
  assign consume = validQ && !bus.stall;
  assign fill    = (state == ST_WAIT) && bus.imemValid && !discard;
  assign pcInc   = pc + 9'd1;

  assign bus.imemReq    = issue;
  assign bus.imemAddr   = pc;
  assign bus.instrOut   = instrQ;
  assign bus.nextPCOut  = nextPCQ;
  assign bus.fetchValid = validQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
      instrQ  <= 32'h0;
      nextPCQ <= 9'd0;
      validQ  <= 1'b0;
    end else if (bus.redirect) begin
      pc      <= bus.redirectPC;
      validQ  <= 1'b0;
      instrQ  <= 32'h0;
      nextPCQ <= 9'd0;
      // Still owed a response after this edge: wait for it and throw it away.
      if (issue || ((state == ST_WAIT) && !bus.imemValid)) begin
        state   <= ST_WAIT;
        discard <= 1'b1;
      end else begin
        state   <= ST_REQ;
        discard <= 1'b0;
      end
    end else begin
      if (state == ST_REQ) begin
        if (issue) begin
          state <= ST_WAIT;
        end
      end else if (bus.imemValid) begin
        state   <= ST_REQ;
        discard <= 1'b0;
        if (!discard) begin
          pc <= pcInc;
        end
      end

      if (fill) begin
        instrQ  <= bus.imemData;
        nextPCQ <= pcInc;
        validQ  <= 1'b1;
      end else if (consume) begin
        instrQ  <= 32'h0;
        nextPCQ <= 9'd0;
        validQ  <= 1'b0;
      end
    end
  end

endmodule
